axil_slave_regbank: RTL and testbench
=====================================

// Module: axil_slave_regbank
// PURPOSE
//  AXI4-Lite responder exposing NUM_REGS 32-bit read/write registers to an AXI4-Lite initiator.
//  Sits behind the master VIP / SPI-AXIM bridge as the S00_AXI endpoint; drives register contents
//  to fabric logic and flags each write with a one-cycle strobe.
// PARAMETERS
//  ADDR_WIDTH   4    byte-address width; register index = addr[ADDR_WIDTH-1:2]
//  DATA_WIDTH   32   data width (fixed 32; WSTRB = 4 bits)
//  NUM_REGS     4    implemented registers, indices 0..NUM_REGS-1 (<= 2**(ADDR_WIDTH-2))
// PORTS
//  ACLK           in   1                   clock, all logic rising-edge
//  ARESETN        in   1                   async active-low reset
//  S_AXI_AWADDR   in   ADDR_WIDTH          write address
//  S_AXI_AWPROT   in   3                   ignored
//  S_AXI_AWVALID  in   1  / S_AXI_AWREADY out 1   AW handshake
//  S_AXI_WDATA    in   32                  write data
//  S_AXI_WSTRB    in   4                   byte enables
//  S_AXI_WVALID   in   1  / S_AXI_WREADY  out 1   W handshake
//  S_AXI_BRESP    out  2                   00 OKAY, 10 SLVERR
//  S_AXI_BVALID   out  1  / S_AXI_BREADY  in  1   B handshake
//  S_AXI_ARADDR   in   ADDR_WIDTH          read address
//  S_AXI_ARPROT   in   3                   ignored
//  S_AXI_ARVALID  in   1  / S_AXI_ARREADY out 1   AR handshake
//  S_AXI_RDATA    out  32                  read data
//  S_AXI_RRESP    out  2                   00 OKAY, 10 SLVERR
//  S_AXI_RVALID   out  1  / S_AXI_RREADY  in  1   R handshake
//  regs_o         out  NUM_REGS*32         register contents, reg i at [32*i+:32]
//  wr_stb_o       out  NUM_REGS            1-cycle pulse, bit i when reg i written
// BEHAVIOUR
//  Reset (ARESETN=0, async): all regs 0; all READY/VALID 0; BRESP/RRESP 00; RDATA 0; wr_stb_o 0.
//   Any in-flight transaction is abandoned; no response issued after release.
//  Write path, states W_IDLE -> W_RESP -> W_IDLE:
//   - AW and W captured independently: AWREADY=1 while no AW held and state=W_IDLE; same for WREADY/W.
//     Either may arrive first, any gap; each READY drops the cycle after its own handshake.
//   - Cycle after both held: reg[idx] updated per WSTRB byte lanes (unset lanes keep old value),
//     wr_stb_o[idx]=1 for that one cycle, BVALID=1, state W_RESP.
//   - W_RESP: BVALID, BRESP stable until BVALID&&BREADY; then W_IDLE, READYs re-open next cycle.
//     Max one write outstanding; AWVALID/WVALID during W_RESP stall.
//   - Write latency: last of AW/W handshake at edge N -> BVALID high after edge N+1.
//  Read path, states R_IDLE -> R_RESP -> R_IDLE:
//   - ARREADY=1 in R_IDLE. On AR handshake at edge N: RDATA/RRESP registered, RVALID=1 after edge N.
//   - R_RESP: ARREADY=0; RDATA, RRESP held until RVALID&&RREADY; then R_IDLE.
//  Decode: addr[1:0] ignored (unaligned maps to containing word). idx >= NUM_REGS:
//   write discarded, no strobe, BRESP=10; read RDATA=0, RRESP=10.
//  Simultaneous read and write to same reg committing on the same edge: read returns OLD value.
//  Read and write paths fully independent; both may complete in the same cycle.
//  WSTRB=0000: OKAY response, reg unchanged, wr_stb_o still pulses.
// TESTING
//  1 Write 1,2,3,4 to 0x0,0x4,0x8,0xC, then read back -> RDATA 1,2,3,4, all RESP 00, regs_o matches.
//  2 reg0=0x11223344; write 0xAABBCCDD WSTRB 0011 -> read 0x1122CCDD; wr_stb_o[0] one cycle.
//  3 WVALID 3 cycles before AWVALID (addr 0x8, data 0x5A) -> single write, BVALID 1 cycle after AW hs.
//  4 BREADY low 5 cycles, second AW/W presented -> BVALID/BRESP stable, AWREADY=WREADY=0 until B hs.
//  5 Write/read addr 0x10 (NUM_REGS=4) -> BRESP 10 regs unchanged; RDATA 0 RRESP 10.
//  6 Assert ARESETN=0 while BVALID=1 and RVALID=1 -> all VALIDs 0, regs 0, no response after release.

Source files
------------

// File: rtl/axil_slave_regbank.sv
// Purpose: AXI4-Lite responder exposing NUM_REGS 32-bit R/W registers to fabric, with a per-register write strobe.
// Latency: write -> BVALID one cycle after the later of the AW/W handshakes; read -> RVALID the cycle after the AR handshake.
// Backpressure: one write and one read outstanding; AW/W/AR stall (READY low) until the pending B/R response is accepted.
//
// Ports:
//   ACLK, ARESETN               clock (rising edge) and async active-low reset
//   S_AXI_AW*/W*/B*             AXI4-Lite write address, data and response channels (AWPROT ignored)
//   S_AXI_AR*/R*                AXI4-Lite read address and data channels (ARPROT ignored)
//   regs_o                      register contents, reg i at [DATA_WIDTH*i +: DATA_WIDTH]
//   wr_stb_o                    one-cycle pulse on bit i when reg i is written
module axil_slave_regbank #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_stb_o
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam int SW = DATA_WIDTH / 8;
  // One extra bit so NUM_REGS == 2**IW is still representable.
  localparam logic [IW:0] NREGS = (IW+1)'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_RESP } r_state_t;

  w_state_t w_state, w_state_nx;
  r_state_t r_state, r_state_nx;

  // Holds all READYs low while reset is asserted and for the first cycle after release.
  logic                  ready_en;
  logic                  aw_held;
  logic [IW-1:0]         aw_idx;
  logic                  w_held;
  logic [DATA_WIDTH-1:0] w_data;
  logic [SW-1:0]         w_strb;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_stb;
  logic [1:0]            b_resp;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic [DATA_WIDTH-1:0] rd_sel;

  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic [IW-1:0] ar_idx;
  logic          aw_in_range, ar_in_range;

  assign S_AXI_AWREADY = ready_en && !aw_held && (w_state == W_IDLE);
  assign S_AXI_WREADY  = ready_en && !w_held  && (w_state == W_IDLE);
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_BRESP   = b_resp;
  assign S_AXI_ARREADY = ready_en && (r_state == R_IDLE);
  assign S_AXI_RVALID  = (r_state == R_RESP);
  assign S_AXI_RDATA   = r_data;
  assign S_AXI_RRESP   = r_resp;
  assign wr_stb_o      = wr_stb;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign b_hs   = S_AXI_BVALID && S_AXI_BREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs   = S_AXI_RVALID && S_AXI_RREADY;
  // aw_held/w_held can only be set in W_IDLE, so commit never overlaps an AW/W handshake.
  assign commit = (w_state == W_IDLE) && aw_held && w_held;

  assign ar_idx      = S_AXI_ARADDR[ADDR_WIDTH-1:2];
  assign aw_in_range = ({1'b0, aw_idx} < NREGS);
  assign ar_in_range = ({1'b0, ar_idx} < NREGS);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Read mux; only implemented indices can match, anything else reads as zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IW'(i)) rd_sel = regs[i];
    end
  end

  always_comb begin
    w_state_nx = w_state;
    r_state_nx = r_state;
    case (w_state)
      W_IDLE:  if (commit) w_state_nx = W_RESP;
      W_RESP:  if (b_hs)   w_state_nx = W_IDLE;
      default: w_state_nx = W_IDLE;
    endcase
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nx = R_RESP;
      R_RESP:  if (r_hs)  r_state_nx = R_IDLE;
      default: r_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nx;
      r_state <= r_state_nx;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_en <= 1'b0;
      aw_held  <= 1'b0;
      aw_idx   <= '0;
      w_held   <= 1'b0;
      w_data   <= '0;
      w_strb   <= '0;
      wr_stb   <= '0;
      b_resp   <= RESP_OKAY;
      r_data   <= '0;
      r_resp   <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      ready_en <= 1'b1;
      wr_stb   <= '0;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        b_resp  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (aw_idx == IW'(i)) begin
            // Strobe fires even with all byte lanes disabled.
            wr_stb[i] <= 1'b1;
            for (int b = 0; b < SW; b++) begin
              if (w_strb[b]) regs[i][8*b +: 8] <= w_data[8*b +: 8];
            end
          end
        end
      end
      // regs are sampled before this edge's commit lands, so a colliding read sees the old value.
      if (ar_hs) begin
        r_data <= ar_in_range ? rd_sel : '0;
        r_resp <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axil_slave_regbank.sv
// Purpose: self-checking bench for axil_slave_regbank; expected B/R responses are queued at issue and checked by a monitor.
// Latency: drives inputs 1 time unit after the rising edge, samples outputs on the falling edge.
// Backpressure: exercises AW/W skew, BREADY stalls, same-register read/write collision and reset mid-response.
module tb_axil_slave_regbank;
  localparam int AW = 5;
  localparam int NR = 4;

  logic            ACLK = 1'b0;
  logic            ARESETN = 1'b0;
  logic [AW-1:0]   S_AXI_AWADDR = '0;
  logic [2:0]      S_AXI_AWPROT = '0;
  logic            S_AXI_AWVALID = 1'b0;
  logic            S_AXI_AWREADY;
  logic [31:0]     S_AXI_WDATA = '0;
  logic [3:0]      S_AXI_WSTRB = '0;
  logic            S_AXI_WVALID = 1'b0;
  logic            S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY = 1'b0;
  logic [AW-1:0]   S_AXI_ARADDR = '0;
  logic [2:0]      S_AXI_ARPROT = '0;
  logic            S_AXI_ARVALID = 1'b0;
  logic            S_AXI_ARREADY;
  logic [31:0]     S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY = 1'b0;
  logic [NR*32-1:0] regs_o;
  logic [NR-1:0]   wr_stb_o;

  always #5 ACLK = ~ACLK;

  axil_slave_regbank #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .regs_o(regs_o), .wr_stb_o(wr_stb_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];   // {RRESP, RDATA}
  int stb_cnt[NR];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: strobe counting and response scoreboard, sampled mid-cycle.
  always @(negedge ACLK) begin
    for (int i = 0; i < NR; i++) if (wr_stb_o[i]) stb_cnt[i]++;
    if (S_AXI_BVALID && S_AXI_BREADY) begin
      if (exp_b.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_unexpected: got BRESP %0h, required no response", S_AXI_BRESP);
      end else check("bresp", 128'(S_AXI_BRESP), 128'(exp_b.pop_front()));
    end
    if (S_AXI_RVALID && S_AXI_RREADY) begin
      if (exp_r.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL r_unexpected: got RRESP/RDATA %0h, required no response", {S_AXI_RRESP, S_AXI_RDATA});
      end else check("rresp_rdata", 128'({S_AXI_RRESP, S_AXI_RDATA}), 128'(exp_r.pop_front()));
    end
  end

  // One clock: observe handshakes at the falling edge, retire the accepted VALIDs after the rising edge.
  task automatic step(output logic b_hs, output logic r_hs);
    logic aw_h, w_h, ar_h;
    @(negedge ACLK);
    aw_h = S_AXI_AWVALID && S_AXI_AWREADY;
    w_h  = S_AXI_WVALID && S_AXI_WREADY;
    ar_h = S_AXI_ARVALID && S_AXI_ARREADY;
    b_hs = S_AXI_BVALID && S_AXI_BREADY;
    r_hs = S_AXI_RVALID && S_AXI_RREADY;
    @(posedge ACLK); #1;
    if (aw_h) S_AXI_AWVALID = 1'b0;
    if (w_h)  S_AXI_WVALID = 1'b0;
    if (ar_h) S_AXI_ARVALID = 1'b0;
  endtask

  task automatic wait_b(input string name);
    logic b, r;
    bit done = 0;
    for (int n = 0; n < 40 && !done; n++) begin step(b, r); done = b; end
    if (!done) begin n_cmp++; n_bad++; $display("FAIL %s: got no B handshake, required one within 40 cycles", name); end
  endtask

  task automatic wait_r(input string name);
    logic b, r;
    bit done = 0;
    for (int n = 0; n < 40 && !done; n++) begin step(b, r); done = r; end
    if (!done) begin n_cmp++; n_bad++; $display("FAIL %s: got no R handshake, required one within 40 cycles", name); end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] resp);
    exp_b.push_back(resp);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    wait_b("wr");
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [31:0] d, input logic [1:0] resp);
    exp_r.push_back({resp, d});
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    wait_r("rd");
    S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic b, r;
    logic [127:0] snap;
    int stb_sum;

    // Reset state
    #12;
    check("rst_ready", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b000));
    check("rst_valid_resp", 128'({S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP}), 128'(6'b0));
    check("rst_rdata_stb", 128'({S_AXI_RDATA, wr_stb_o}), 128'(0));
    check("rst_regs", regs_o, 128'(0));
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    check("post_rst_ready", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b111));

    // 1: write 1..4, read back
    for (int i = 0; i < 4; i++) wr(AW'(4*i), 32'(i+1), 4'hF, 2'b00);
    for (int i = 0; i < 4; i++) rd(AW'(4*i), 32'(i+1), 2'b00);
    check("t1_regs", regs_o, {32'd4, 32'd3, 32'd2, 32'd1});
    check("t1_stb", 128'({stb_cnt[3], stb_cnt[2], stb_cnt[1], stb_cnt[0]}), {32'd1, 32'd1, 32'd1, 32'd1});

    // 2: partial byte-lane write
    wr(5'h0, 32'h11223344, 4'hF, 2'b00);
    wr(5'h0, 32'hAABBCCDD, 4'b0011, 2'b00);
    rd(5'h0, 32'h1122CCDD, 2'b00);
    check("t2_reg0", 128'(regs_o[31:0]), 128'(32'h1122CCDD));
    check("t2_stb0", 128'(stb_cnt[0]), 128'(3));
    rd(5'h6, 32'd2, 2'b00);   // unaligned address maps to reg1

    // 3: W leads AW by three cycles
    exp_b.push_back(2'b00);
    S_AXI_AWADDR = 5'h8; S_AXI_WDATA = 32'h5A; S_AXI_WSTRB = 4'hF;
    S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    step(b, r);
    check("t3_ready_after_w", 128'({S_AXI_WREADY, S_AXI_AWREADY}), 128'(2'b01));
    step(b, r); step(b, r);
    S_AXI_AWVALID = 1'b1;
    step(b, r);
    check("t3_bvalid_at_hs", 128'(S_AXI_BVALID), 128'(0));
    step(b, r);
    check("t3_bvalid_stb", 128'({S_AXI_BVALID, wr_stb_o}), 128'(5'b1_0100));
    S_AXI_BREADY = 1'b1;
    wait_b("t3_b");
    S_AXI_BREADY = 1'b0;
    check("t3_reg2", 128'(regs_o[64 +: 32]), 128'(32'h5A));
    check("t3_stb2", 128'(stb_cnt[2]), 128'(2));

    // 4: BREADY held low with a second write waiting
    exp_b.push_back(2'b00);
    exp_b.push_back(2'b00);
    S_AXI_AWADDR = 5'h4; S_AXI_WDATA = 32'hA1; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    step(b, r); step(b, r);
    S_AXI_AWADDR = 5'hC; S_AXI_WDATA = 32'hB2;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge ACLK);
      check("t4_stall", 128'({S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY}), 128'(5'b10000));
      @(posedge ACLK); #1;
    end
    S_AXI_BREADY = 1'b1;
    wait_b("t4_b1");
    wait_b("t4_b2");
    S_AXI_BREADY = 1'b0;
    check("t4_regs", 128'({regs_o[96 +: 32], regs_o[32 +: 32]}), 128'({32'hB2, 32'hA1}));

    // 5: out-of-range index
    snap = regs_o;
    stb_sum = stb_cnt[0] + stb_cnt[1] + stb_cnt[2] + stb_cnt[3];
    wr(5'h10, 32'hFFFFFFFF, 4'hF, 2'b10);
    check("t5_regs", regs_o, snap);
    check("t5_stb", 128'(stb_cnt[0] + stb_cnt[1] + stb_cnt[2] + stb_cnt[3]), 128'(stb_sum));
    rd(5'h10, 32'h0, 2'b10);
    rd(5'h13, 32'h0, 2'b10);

    // Read and write to reg3 on the same edge: read sees the old value
    exp_b.push_back(2'b00);
    exp_r.push_back({2'b00, 32'hB2});
    S_AXI_AWADDR = 5'hC; S_AXI_WDATA = 32'hC3; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    step(b, r);
    S_AXI_ARADDR = 5'hC; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    wait_b("t7_b");
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    check("t7_rq_drained", 128'(exp_r.size()), 128'(0));
    rd(5'hC, 32'hC3, 2'b00);

    // 6: reset while BVALID and RVALID are both high
    S_AXI_AWADDR = 5'h0; S_AXI_WDATA = 32'hDEAD; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 5'h4; S_AXI_ARVALID = 1'b1;
    step(b, r); step(b, r);
    check("t6_both_valid", 128'({S_AXI_BVALID, S_AXI_RVALID}), 128'(2'b11));
    #2 ARESETN = 1'b0;
    #1;
    check("t6_rst_outputs", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID,
                                  S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, wr_stb_o}), 128'(0));
    check("t6_rst_regs", regs_o, 128'(0));
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge ACLK);
      check("t6_no_resp", 128'({S_AXI_BVALID, S_AXI_RVALID}), 128'(2'b00));
      @(posedge ACLK); #1;
    end
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    rd(5'h0, 32'h0, 2'b00);
    rd(5'h4, 32'h0, 2'b00);

    check("b_queue_empty", 128'(exp_b.size()), 128'(0));
    check("r_queue_empty", 128'(exp_r.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
